// File: rtl/apu_timer_multi.sv
// apu_timer_multi: multi-channel countdown timer for the APU with its own APB slave.
// A shared prescaler produces a one-cycle tick; each enabled channel steps on that
// tick, periodic or one-shot, and expiries set sticky W1C flags feeding one level irq.
// Optional feature macro: APU_TIMER_CHAIN_EN -- channel i>0 with CTRL.CHAIN=1 steps
// on channel i-1's expiry pulse instead of tick. Undefined: CHAIN is RAZ/WI.
module apu_timer_multi #(
    parameter int N_TIMERS = 4,
    parameter int W_CTR    = 24,
    parameter int W_TICK   = 8,
    parameter int W_ADDR   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              apbs_psel,
    input  logic              apbs_penable,
    input  logic              apbs_pwrite,
    input  logic [W_ADDR-1:0] apbs_paddr,
    input  logic [31:0]       apbs_pwdata,
    output logic [31:0]       apbs_prdata,
    output logic              apbs_pready,
    output logic              apbs_pslverr,
    output logic              irq
);
    localparam int WORD_W = W_ADDR - 2;

    logic [WORD_W-1:0]   word;
    logic                wr;
    logic                rd;
    logic                sel_tick;
    logic                sel_intr;
    logic                sel_inte;
    logic [N_TIMERS-1:0] sel_ctrl;
    logic [N_TIMERS-1:0] sel_reload;
    logic [N_TIMERS-1:0] sel_ctr;

    logic [W_TICK-1:0]   tick_period;
    logic [W_TICK-1:0]   pctr;
    logic                tick;

    logic [N_TIMERS-1:0] intr;
    logic [N_TIMERS-1:0] inte;
    logic [N_TIMERS-1:0] w1c;

    logic [N_TIMERS-1:0] en;
    logic [N_TIMERS-1:0] periodic;
    logic [N_TIMERS-1:0] chain;
    logic [W_CTR-1:0]    reload_val [N_TIMERS];
    logic [W_CTR-1:0]    ctr        [N_TIMERS];
    logic [N_TIMERS-1:0] step;
    logic [N_TIMERS-1:0] expire;

    logic [31:0]         rdata;
    logic                unused_bits;

    assign word         = apbs_paddr[W_ADDR-1:2];
    assign wr           = apbs_psel & apbs_penable & apbs_pwrite;
    assign rd           = apbs_psel & apbs_penable & ~apbs_pwrite;
    assign apbs_pready  = 1'b1;
    assign apbs_pslverr = 1'b0;
    assign unused_bits  = ^{apbs_paddr[1:0], apbs_pwdata};

    assign tick = (pctr == '0);
    assign w1c  = (wr & sel_intr) ? apbs_pwdata[N_TIMERS-1:0] : '0;
    assign irq  = |(intr & inte);

    // Word-address decode of the register map; channel blocks start at 0x10.
    always_comb begin
        sel_tick   = (word == WORD_W'(0));
        sel_intr   = (word == WORD_W'(1));
        sel_inte   = (word == WORD_W'(2));
        sel_ctrl   = '0;
        sel_reload = '0;
        sel_ctr    = '0;
        for (int i = 0; i < N_TIMERS; i++) begin
            sel_ctrl[i]   = (word == WORD_W'(4 * (i + 1)));
            sel_reload[i] = (word == WORD_W'(4 * (i + 1) + 1));
            sel_ctr[i]    = (word == WORD_W'(4 * (i + 1) + 2));
        end
    end

    // Prescaler: count down to zero, tick there, reload; a TICK write restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pctr <= '0;
        end else if (wr && sel_tick) begin
            pctr <= apbs_pwdata[W_TICK-1:0];
        end else if (tick) begin
            pctr <= tick_period;
        end else begin
            pctr <= pctr - W_TICK'(1);
        end
    end

    // Global registers; an expiry in the same cycle wins over the W1C clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_period <= '0;
            inte        <= '0;
            intr        <= '0;
        end else begin
            if (wr && sel_tick) tick_period <= apbs_pwdata[W_TICK-1:0];
            if (wr && sel_inte) inte <= apbs_pwdata[N_TIMERS-1:0];
            intr <= (intr & ~w1c) | expire;
        end
    end

    // Step enables, walked in channel order so a chained channel sees its
    // predecessor's expiry pulse in the same cycle.
    always_comb begin
        logic src;
`ifdef APU_TIMER_CHAIN_EN
        logic prev;
        prev = 1'b0;
`endif
        step   = '0;
        expire = '0;
        for (int i = 0; i < N_TIMERS; i++) begin
            src = tick;
`ifdef APU_TIMER_CHAIN_EN
            if (i > 0 && chain[i]) src = prev;
`endif
            step[i]   = src & en[i];
            expire[i] = step[i] & (ctr[i] == W_CTR'(1));
`ifdef APU_TIMER_CHAIN_EN
            prev = expire[i];
`endif
        end
    end

`ifdef APU_TIMER_CHAIN_EN
    // CHAIN control bits, stored on every channel but only acted on for i>0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            for (int i = 0; i < N_TIMERS; i++) begin
                if (wr && sel_ctrl[i]) chain[i] <= apbs_pwdata[2];
            end
        end
    end
`else
    assign chain = '0;
`endif

    // Per-channel control and counter; APB writes take priority over stepping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en       <= '0;
            periodic <= '0;
            for (int i = 0; i < N_TIMERS; i++) begin
                reload_val[i] <= '0;
                ctr[i]        <= '0;
            end
        end else begin
            for (int i = 0; i < N_TIMERS; i++) begin
                if (wr && sel_ctrl[i]) begin
                    en[i]       <= apbs_pwdata[0];
                    periodic[i] <= apbs_pwdata[1];
                end else if (expire[i] && !periodic[i]) begin
                    en[i] <= 1'b0;
                end

                if (wr && sel_reload[i]) reload_val[i] <= apbs_pwdata[W_CTR-1:0];

                if (wr && sel_ctr[i]) begin
                    ctr[i] <= apbs_pwdata[W_CTR-1:0];
                end else if (step[i]) begin
                    if (ctr[i] == W_CTR'(1)) begin
                        ctr[i] <= '0;
                    end else if (ctr[i] == '0) begin
                        if (periodic[i]) ctr[i] <= reload_val[i];
                    end else begin
                        ctr[i] <= ctr[i] - W_CTR'(1);
                    end
                end
            end
        end
    end

    // Read mux; unmapped addresses and unused bits return zero.
    always_comb begin
        rdata = '0;
        if (sel_tick) rdata = 32'(tick_period);
        if (sel_intr) rdata = 32'(intr);
        if (sel_inte) rdata = 32'(inte);
        for (int i = 0; i < N_TIMERS; i++) begin
            if (sel_ctrl[i])   rdata = {29'd0, chain[i], periodic[i], en[i]};
            if (sel_reload[i]) rdata = 32'(reload_val[i]);
            if (sel_ctr[i])    rdata = 32'(ctr[i]);
        end
    end

    assign apbs_prdata = rd ? rdata : 32'd0;

endmodule
